// File: rtl/alu_pkg.sv
// Shared opcodes, widths, FSM states and command payload for the ALU issue queue.
package alu_pkg;

    localparam int unsigned OP_W    = 2;
    localparam int unsigned DATA_W  = 4;
    localparam int unsigned SHIFT_W = 2;

    localparam logic [OP_W-1:0] OP_SRA = 2'd0;
    localparam logic [OP_W-1:0] OP_SRL = 2'd1;
    localparam logic [OP_W-1:0] OP_SUB = 2'd2;
    localparam logic [OP_W-1:0] OP_ADD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [OP_W-1:0]    op;
        logic [DATA_W-1:0]  a;
        logic [DATA_W-1:0]  b;
        logic [SHIFT_W-1:0] c;
    } cmd_t;

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO: power-of-two depth, registered count/full/empty, no write-to-read bypass.
module cmd_fifo
    import alu_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  cmd_t             push_data,
    input  logic             pop,
    output cmd_t             head_c,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    cmd_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    // Full is registered, so a full FIFO refuses a push even while popping.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        count_next = count;
        if (do_push && !do_pop) begin
            count_next = count + CNT_W'(1);
        end else if (!do_push && do_pop) begin
            count_next = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            full  <= (count_next == CNT_W'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head_c = mem[rd_ptr];

endmodule

// File: rtl/alu_issue_queue.sv
// Queues ALU commands, issues them one at a time to an external combinational ALU
// and holds each result until the consumer takes it.
module alu_issue_queue
    import alu_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [OP_W-1:0]    in_op,
    input  logic [DATA_W-1:0]  in_a,
    input  logic [DATA_W-1:0]  in_b,
    input  logic [SHIFT_W-1:0] in_c,
    output logic [OP_W-1:0]    alu_op,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [SHIFT_W-1:0] alu_c,
    input  logic [DATA_W-1:0]  alu_ans,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_ans,
    output logic [OP_W-1:0]    out_op,
    output logic               out_zero,
    output logic [CNT_W-1:0]   count
);

    state_t state;
    state_t state_next;
    cmd_t   head_c;
    cmd_t   in_cmd;
    logic   full;
    logic   empty;
    logic   push;
    logic   issue;
    logic   capture;
    logic   retire;

    assign in_cmd   = '{op: in_op, a: in_a, b: in_b, c: in_c};
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (in_cmd),
        .pop       (issue),
        .head_c    (head_c),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Issue from IDLE or straight out of a HOLD handshake; EXEC always lasts one cycle.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        capture    = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    issue      = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                capture    = 1'b1;
                state_next = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    retire = 1'b1;
                    if (!empty) begin
                        issue      = 1'b1;
                        state_next = EXEC;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op    <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_c     <= '0;
            out_valid <= 1'b0;
            out_ans   <= '0;
            out_op    <= '0;
            out_zero  <= 1'b0;
        end else begin
            if (issue) begin
                alu_op <= head_c.op;
                alu_a  <= head_c.a;
                alu_b  <= head_c.b;
                alu_c  <= head_c.c;
            end
            if (capture) begin
                out_valid <= 1'b1;
                out_ans   <= alu_ans;
                out_op    <= alu_op;
                out_zero  <= (alu_ans == '0);
            end else if (retire) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Scoreboard bench for alu_issue_queue with a behavioural ALU attached to the alu_* port.
module tb_alu_issue_queue;
    import alu_pkg::*;

    typedef struct packed {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] c;
        logic [3:0] exp;
    } vec_t;

    typedef struct packed {
        logic [3:0] ans;
        logic [1:0] op;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_op;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [1:0] in_c;
    logic [1:0] alu_op;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [1:0] alu_c;
    logic [3:0] alu_ans;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_ans;
    logic [1:0] out_op;
    logic       out_zero;
    logic [2:0] count;

    int   checks = 0;
    int   passes = 0;
    int   cyc = 0;
    exp_t sb[$];
    int   hs_cyc[$];
    vec_t bp_v [6];
    vec_t wrap_v [12];
    vec_t same_v [4];
    vec_t rst_v [4];

    alu_issue_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_c      (in_c),
        .alu_op    (alu_op),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .alu_ans   (alu_ans),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ans   (out_ans),
        .out_op    (out_op),
        .out_zero  (out_zero),
        .count     (count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always_comb begin
        case (alu_op)
            OP_SRA:  alu_ans = 4'($signed(alu_a) >>> alu_c);
            OP_SRL:  alu_ans = alu_a >> alu_c;
            OP_SUB:  alu_ans = alu_a - alu_b;
            default: alu_ans = alu_a + alu_b;
        endcase
    end

    function automatic vec_t mk(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                                input logic [1:0] c, input logic [3:0] exp);
        mk = '{op: op, a: a, b: b, c: c, exp: exp};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        in_valid = 1'b1;
        in_op    = v.op;
        in_a     = v.a;
        in_b     = v.b;
        in_c     = v.c;
    endtask

    // Presents one command until accepted; the expected result enters the scoreboard on acceptance.
    task automatic send(input vec_t v);
        drive(v);
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp_t'{v.exp, v.op});
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("send_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int n = 0; n < 200; n++) begin
            if (sb.size() == 0 && !out_valid && count == 3'd0) return;
            @(posedge clk);
            #1;
        end
        check(name, 0, 1);
    endtask

    // While a result is presented it must equal the scoreboard head; a handshake retires it.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                check("result", int'({out_ans, out_op, out_zero}),
                      int'({sb[0].ans, sb[0].op, sb[0].ans == 4'd0}));
                if (out_ready) begin
                    void'(sb.pop_front());
                    hs_cyc.push_back(cyc);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int seen;

        bp_v   = '{mk(3, 4'd1, 4'd1, 0, 4'd2), mk(3, 4'd2, 4'd2, 0, 4'd4),
                   mk(2, 4'd9, 4'd3, 0, 4'd6), mk(1, 4'b1100, 4'd0, 1, 4'b0110),
                   mk(0, 4'b1100, 4'd0, 1, 4'b1110), mk(3, 4'd5, 4'd5, 0, 4'd10)};
        wrap_v = '{mk(3, 4'd1, 4'd2, 0, 4'd3), mk(2, 4'd5, 4'd7, 0, 4'b1110),
                   mk(0, 4'b1010, 4'd0, 1, 4'b1101), mk(1, 4'b1010, 4'd0, 1, 4'b0101),
                   mk(3, 4'd15, 4'd1, 0, 4'd0), mk(2, 4'd0, 4'd1, 0, 4'd15),
                   mk(0, 4'b0110, 4'd0, 3, 4'b0000), mk(1, 4'b1111, 4'd0, 3, 4'b0001),
                   mk(0, 4'b1111, 4'd0, 3, 4'b1111), mk(3, 4'd8, 4'd8, 0, 4'd0),
                   mk(2, 4'd9, 4'd4, 0, 4'd5), mk(3, 4'd6, 4'd3, 0, 4'd9)};
        same_v = '{mk(3, 4'd3, 4'd4, 0, 4'd7), mk(2, 4'd2, 4'd3, 0, 4'd15),
                   mk(1, 4'b0100, 4'd0, 2, 4'b0001), mk(3, 4'd12, 4'd4, 0, 4'd0)};
        rst_v  = '{mk(3, 4'd1, 4'd1, 0, 4'd2), mk(3, 4'd2, 4'd1, 0, 4'd3),
                   mk(3, 4'd3, 4'd1, 0, 4'd4), mk(3, 4'd4, 4'd1, 0, 4'd5)};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = '0; in_a = '0; in_b = '0; in_c = '0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_regs", int'({out_ans, out_op, out_zero}), 0);
        check("rst_alu_regs", int'({alu_op, alu_a, alu_b, alu_c}), 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Add wrap to zero and issue latency
        out_ready = 1'b1;
        send(mk(OP_ADD, 4'b0111, 4'b1001, 0, 4'b0000));
        check("lat_edge_n", out_valid, 0);
        @(posedge clk); #1;
        check("lat_edge_n1", out_valid, 0);
        check("issue_operands", int'({alu_op, alu_a, alu_b}), int'({2'd3, 4'd7, 4'd9}));
        @(posedge clk); #1;
        check("lat_edge_n2", out_valid, 1);
        wait_idle("add_wrap_drain");

        // Shifts and subtract, back to back
        send(mk(OP_SRA, 4'b1000, 4'd0, 2, 4'b1110));
        send(mk(OP_SRL, 4'b1000, 4'd0, 2, 4'b0010));
        send(mk(OP_SUB, 4'b0011, 4'b0101, 0, 4'b1110));
        wait_idle("shift_sub_drain");
        check("alu_hold_last", int'({alu_op, alu_a, alu_b}), int'({2'd2, 4'd3, 4'd5}));

        // Backpressure: offer commands continuously with the consumer stalled
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 10; i++) begin
            drive(bp_v[acc]);
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(exp_t'{bp_v[acc].exp, bp_v[acc].op});
                acc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", acc, 5);
        check("bp_in_ready", in_ready, 0);
        check("bp_count", count, 4);

        // Drain the full queue
        hs_cyc.delete();
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain_in_ready", in_ready, 1);
        check("drain_count", count, 3);
        wait_idle("drain_idle");
        check("drain_results", hs_cyc.size(), 5);
        for (int i = 1; i < hs_cyc.size(); i++) check("drain_gap", hs_cyc[i] - hs_cyc[i-1], 2);

        // Push and pop on the same edge with two queued
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(same_v[i]);
        check("same_pre_count", count, 2);
        check("same_pre_valid", out_valid, 1);
        drive(same_v[3]);
        out_ready = 1'b1;
        @(negedge clk);
        check("same_in_ready", in_ready, 1);
        sb.push_back(exp_t'{same_v[3].exp, same_v[3].op});
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("same_count", count, 2);
        wait_idle("same_drain");

        // Pointer wrap with ordering over a stream
        for (int i = 0; i < 12; i++) send(wrap_v[i]);
        wait_idle("wrap_drain");

        // Reset while holding a result with three queued
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(rst_v[i]);
        check("rst_mid_pre_valid", out_valid, 1);
        check("rst_mid_pre_count", count, 3);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_count", count, 0);
        check("rst_mid_in_ready", in_ready, 1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("rst_no_stale", seen, 0);
        check("sb_empty_end", sb.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports in_valid (input, 1) and in_ready (output, 1): command handshake.
REQ-005 SHALL have in_op input 2 (opcode), in_a input 4, in_b input 4 and in_c input 2 (shift amount).
REQ-006 SHALL have alu_op output 2, alu_a output 4, alu_b output 4 and alu_c output 2: registered operands driving the downstream combinational ALU.
REQ-007 SHALL have alu_ans, input, 4: combinational result returned by the ALU.
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1): result handshake.
REQ-009 SHALL have out_ans output 4 (result), out_op output 2 (opcode echo), out_zero output 1 (out_ans == 0) and count output 3 (FIFO occupancy).

Function
REQ-010 Opcodes: 0 = arithmetic right shift of a by c, 1 = logical right shift, 2 = a-b mod 16, 3 = a+b mod 16; the block does no arithmetic itself.
REQ-011 A command SHALL be accepted on a rising edge where in_valid && in_ready, and pushed to the FIFO tail.
REQ-012 in_ready SHALL be (count < DEPTH), driven from registered state only; a full FIFO SHALL refuse push even when a pop occurs in the same cycle.
REQ-013 FSM states SHALL be IDLE, EXEC and HOLD.
REQ-014 IDLE with count > 0: pop the FIFO head into the alu_* registers and go to EXEC; IDLE with count == 0: stay in IDLE.
REQ-015 EXEC (exactly 1 cycle): capture alu_ans into out_ans and the issued opcode into out_op, set out_valid, go to HOLD.
REQ-016 HOLD: out_valid=1; out_ans, out_op and out_zero SHALL remain stable until out_valid && out_ready.
REQ-017 At the HOLD handshake: if count > 0, pop the next command and go to EXEC; otherwise clear out_valid and go to IDLE.
REQ-018 No bypass: a command pushed into an empty FIFO SHALL become visible to the FSM one cycle later.
REQ-019 Latency: command accepted at edge N into an idle, empty block yields out_valid high from the cycle after edge N+2; sustained throughput is 1 result per 2 cycles.
REQ-020 Simultaneous push and pop SHALL leave count unchanged; pointers wrap modulo DEPTH.
REQ-021 The alu_* outputs SHALL hold the last issued operands outside of EXEC.
REQ-022 Results SHALL emerge in strict acceptance order.

Reset
REQ-023 rst_n low SHALL immediately clear: state to IDLE, FIFO to empty (count=0), and out_valid, out_ans, out_op, out_zero and all alu_* outputs to 0; in_ready is then 1.
REQ-024 Reset mid-operation SHALL discard all queued and in-flight commands with no partial result emitted.

Structure
REQ-025 Package alu_pkg SHALL hold opcode constants (OP_SRA, OP_SRL, OP_SUB, OP_ADD), data/shift widths and the FSM state enum.
REQ-026 Storage SHALL be one sub-module, cmd_fifo (parameterised DEPTH; push/pop/full/empty/count); the FSM and result register live in alu_issue_queue.

Verification
REQ-027 Add wrap: op=3, a=0111, b=1001, ALU attached -> out_ans=0000, out_zero=1, out_op=3, out_valid 3 cycles after acceptance.
REQ-028 Shifts and subtract: (op0, a=1000, c=2) -> 1110; (op1, a=1000, c=2) -> 0010; (op2, a=0011, b=0101) -> 1110; results in that order.
REQ-029 Backpressure: out_ready=0, in_valid=1 continuously -> exactly DEPTH+1 (5) accepted, then in_ready=0 and count=4; out_ans stable throughout.
REQ-030 Drain: release out_ready on a full FIFO -> 5 results at 1 per 2 cycles, in order; in_ready returns on the cycle after the first pop.
REQ-031 Reset mid-operation: assert rst_n=0 in HOLD with count=3 -> out_valid=0, count=0 and in_ready=1 without a clock edge; no stale result after release.
REQ-032 Push and pop on the same edge with count=2 -> count stays 2; pointer wrap is exercised over 10 or more commands with ordering checked.
